mul_rr_sched: RTL and testbench

MUL_RR_SCHED -- requirements
Module: mul_rr_sched

---
 rtl/mul_rr_sched.sv | 110 +++++++++++
 tb/tb_mul_rr_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_sched.sv
// Round-robin arbiter feeding a single signed multiplier.
// Requesters share one product register; each grant runs IDLE -> MUL -> RESP.
module mul_rr_sched #(
  parameter int W   = 3,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [2*W-1:0]   resp_p,
  output logic [IDW-1:0]   resp_id,
  output logic             busy
);

  // state | meaning
  // IDLE  | arbitrate; winner sees req_ready this cycle
  // MUL   | multiply captured operands into resp_p
  // RESP  | hold response until resp_ready
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, b_q;
  logic [IDW-1:0]   id_q, last_q;
  logic [2*W-1:0]   resp_p_q;
  logic [IDW-1:0]   resp_id_q;
  logic             resp_valid_q;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [2*W-1:0]   a_ext, b_ext, prod;

  // Scan upward from the slot after the last winner, wrapping at N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      int sel;
      sel = (int'(last_q) + k) % N;
      if (!win_found && req_valid[IDW'(sel)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(sel);
      end
    end
  end

  // Low 2W bits of the sign-extended product are exact for two's complement.
  assign a_ext = {{W{a_q[W-1]}}, a_q};
  assign b_ext = {{W{b_q[W-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found)  state_d = MUL;
      MUL:                     state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && win_found) req_ready[win_idx] = 1'b1;
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      last_q       <= IDW'(N-1);
      resp_p_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (win_found) begin
          a_q    <= req_a[win_idx*W +: W];
          b_q    <= req_b[win_idx*W +: W];
          id_q   <= win_idx;
          last_q <= win_idx;
        end
        MUL: begin
          resp_p_q     <= prod;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
        end
        RESP: if (resp_ready) resp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_p     = resp_p_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Scoreboard bench for mul_rr_sched: a negedge monitor models arbitration
// and queues expected products at each grant, popping them on handshake.
module tb_mul_rr_sched;
  localparam int W = 3, N = 4, IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid, resp_ready;
  logic [2*W-1:0] resp_p;
  logic [IDW-1:0] resp_id;
  logic           busy;

  int total = 0, bad = 0, cyc_n = 0;
  int m_st = 0, m_last = N-1;
  logic [IDW-1:0] sb_id[$];
  logic [2*W-1:0] sb_p[$];
  int gnt_id[$], gnt_cyc[$];

  mul_rr_sched #(.W(W), .N(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_p(resp_p), .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [5:0] ref_mul(input logic [2:0] a, input logic [2:0] b);
    int sa, sb;
    sa = a[2] ? int'(a) - 8 : int'(a);
    sb = b[2] ? int'(b) - 8 : int'(b);
    return 6'(sa * sb);
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int win;
    cyc_n++;
    if (!rst_n) begin
      chk("rst_rvalid", resp_valid, 0);
      chk("rst_p", resp_p, 0);
      chk("rst_id", resp_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      m_st = 0; m_last = N-1;
      sb_id.delete(); sb_p.delete();
    end else begin
      exp_rdy = '0; win = -1;
      if (m_st == 0)
        for (int k = 1; k <= N; k++)
          if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("ready", req_ready, exp_rdy);
      chk("busy", busy, m_st != 0);
      chk("rvalid", resp_valid, m_st == 2);
      case (m_st)
        0: if (win >= 0) begin
          sb_id.push_back(IDW'(win));
          sb_p.push_back(ref_mul(req_a[win*W +: W], req_b[win*W +: W]));
          gnt_id.push_back(win); gnt_cyc.push_back(cyc_n);
          m_last = win; m_st = 1;
        end
        1: m_st = 2;
        default: if (resp_ready) begin
          if (sb_p.size() == 0) chk("sb_empty", 1, 0);
          else begin
            chk("sb_p", resp_p, sb_p.pop_front());
            chk("sb_id", resp_id, sb_id.pop_front());
          end
          m_st = 0;
        end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic setop(input int i, input logic [2:0] a, input logic [2:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Starts in IDLE with resp_ready high; ends in the following IDLE cycle.
  task automatic xact(input int i, input logic [2:0] a, input logic [2:0] b,
                      input logic [5:0] exp_p, input string tag);
    req_valid = '0; req_valid[i] = 1'b1; setop(i, a, b);
    cyc(); req_valid = '0;
    cyc(); chk(tag, resp_p, exp_p);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    repeat (3) cyc();

    // first grant right after reset: 3 * -2
    rst_n = 1'b1; req_valid = 4'b0001; setop(0, 3'b011, 3'b110);
    #1 chk("gnt0_c0", req_ready, 4'b0001);
    cyc(); req_valid = '0;
    cyc();
    chk("rv_c2", resp_valid, 1);
    chk("p_c2", resp_p, 6'b111010);
    chk("id_c2", resp_id, 0);
    cyc();

    xact(1, 3'b100, 3'b100, 6'b010000, "p_m4m4");
    xact(3, 3'b100, 3'b011, 6'b110100, "p_m4p3");
    xact(0, 3'b000, 3'b100, 6'b000000, "p_0m4");
    xact(2, 3'b111, 3'b001, 6'b111111, "p_m1p1");

    // all requesters continuously valid from a fresh reset
    rst_n = 1'b0; cyc();
    for (int i = 0; i < N; i++) setop(i, 3'(i + 1), 3'(7 - i));
    req_valid = 4'b1111; gnt_id.delete(); gnt_cyc.delete();
    rst_n = 1'b1;
    repeat (13) cyc();
    req_valid = '0;
    repeat (3) cyc();
    chk("gnt_cnt", gnt_id.size(), 5);
    for (int i = 0; i < 5 && i < gnt_id.size(); i++) begin
      chk("gnt_order", gnt_id[i], i % N);
      if (i > 0) chk("gnt_space", gnt_cyc[i] - gnt_cyc[i-1], 3);
    end

    // single continuous requester wins every IDLE cycle
    gnt_id.delete();
    req_valid = 4'b0010; setop(1, 3'b010, 3'b101);
    repeat (7) cyc();
    req_valid = '0;
    repeat (3) cyc();
    chk("solo_cnt", gnt_id.size(), 3);

    // consumer stalls RESP for 5 cycles; requester 2 arrives meanwhile
    resp_ready = 1'b0;
    req_valid = 4'b0010; setop(1, 3'b010, 3'b011);
    cyc(); req_valid = '0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("hold_p", resp_p, 6'b000110);
      chk("hold_id", resp_id, 1);
      chk("hold_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
      req_valid = 4'b0100; setop(2, 3'b101, 3'b010);
      if (i == 1) begin req_valid = 4'b1100; setop(3, 3'b001, 3'b001); end
      if (i == 2) req_valid = 4'b0100;
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    chk("idle_after", busy, 0);
    resp_ready = 1'b0;
    cyc(); setop(2, 3'b011, 3'b011); req_valid = '0;
    cyc();
    chk("late_a_p", resp_p, 6'b111010);
    chk("late_a_id", resp_id, 2);

    // async reset in RESP drops the response without a clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rv", resp_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_p", resp_p, 0);
    req_valid = 4'b1111; resp_ready = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    #1 chk("post_rst_gnt", req_ready, 4'b0001);
    cyc(); req_valid = '0;
    repeat (3) cyc();
    chk("sb_drained", sb_p.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
